icache_fill_unit: RTL and testbench

//  Direct-mapped, read-only instruction cache between the pipelined datapath fetch port and
//  the memory controller instruction port. Serves imemREN/imemaddr from the datapath with a

---
 rtl/icache_fill_unit.sv | 94 +++++++++
 tb/tb_icache_fill_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_unit.sv
// icache_fill_unit: direct-mapped read-only instruction cache with a multi-word block fill FSM
module icache_fill_unit #(
  parameter int SETS      = 16,
  parameter int BLK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  localparam int OB = $clog2(BLK_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int CW = (OB > 0) ? OB : 1;
  localparam int TB = 30 - OB - IB;
  typedef enum logic {IDLE, FILL} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_base;
  logic [31:0]     r_iaddr;
  logic            r_iren;
  logic [SETS-1:0] r_valid;
  logic [TB-1:0]   r_tag  [SETS];
  logic [31:0]     r_data [SETS][BLK_WORDS];
  logic [IB-1:0]   w_idx;
  logic [TB-1:0]   w_tag;
  logic [CW-1:0]   w_off;
  logic [IB-1:0]   w_fidx;
  logic [TB-1:0]   w_ftag;
  logic [31:0]     w_blk;
  logic            w_last;
  logic            w_hit;
  logic            w_unused;
  always_comb begin
    w_idx    = imemaddr[2+OB +: IB];
    w_tag    = imemaddr[31 -: TB];
    w_off    = CW'(imemaddr[31:2] & 30'(BLK_WORDS - 1));
    w_fidx   = r_base[2+OB +: IB];
    w_ftag   = r_base[31 -: TB];
    w_blk    = {imemaddr[31:2+OB], {(2+OB){1'b0}}};
    w_last   = r_cnt == CW'(BLK_WORDS - 1);
    w_hit    = imemREN && r_state == IDLE && !flush && r_valid[w_idx] && r_tag[w_idx] == w_tag;
    w_unused = &{1'b0, imemaddr[1:0]};
    ihit     = w_hit;
    imemload = w_hit ? r_data[w_idx][w_off] : '0;
    iREN     = r_iren;
    iaddr    = r_iaddr;
  end
  // flush outranks a completing last word so an aborted frame never becomes valid
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
      r_iren  <= 1'b0;
      r_iaddr <= '0;
      r_base  <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_iren  <= 1'b0;
      r_iaddr <= '0;
    end else if (r_state == IDLE) begin
      if (imemREN && !w_hit) begin
        r_state <= FILL;
        r_base  <= w_blk;
        r_cnt   <= '0;
        r_iren  <= 1'b1;
        r_iaddr <= w_blk;
      end
    end else if (!iwait) begin
      if (w_last) begin
        r_valid[w_fidx] <= 1'b1;
        r_tag[w_fidx]   <= w_ftag;
        r_state         <= IDLE;
        r_cnt           <= '0;
        r_iren          <= 1'b0;
        r_iaddr         <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_iaddr <= r_base + ((32'(r_cnt) + 32'd1) << 2);
      end
    end
  end
  always_ff @(posedge CLK)
    if (!RST && r_state == FILL && !iwait) r_data[w_fidx][r_cnt] <= iload;
endmodule

// File: tb/tb_icache_fill_unit.sv
// tb_icache_fill_unit: directed tests of hit/miss, fill timing, conflicts, flush and reset
module tb_icache_fill_unit;
  logic        CLK = 0, RST = 1, imemREN = 0, flush = 0, iwait = 0;
  logic [31:0] imemaddr = 0;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, iload;
  int          total = 0, bad = 0;
  icache_fill_unit dut (.CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload));
  always #5 CLK = ~CLK;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 0 ? 32'h11 : a == 4 ? 32'h22 : 32'hC000_0000 | a;
  endfunction
  assign iload = memf(iaddr);

  task automatic fetch(input logic [31:0] a, input int w, output int cyc, output logic [31:0] d, output bit stable);
    logic [31:0] pa;
    bit pw;
    int wc;
    imemREN = 1; imemaddr = a; wc = 0; pw = 0; pa = 0; stable = 1; cyc = -1; d = 0;
    for (int c = 0; c < 100; c++) begin
      iwait = iREN && (wc < w);
      #1;
      if (pw && iaddr !== pa) stable = 0;
      if (ihit) begin cyc = c; d = imemload; break; end
      pw = iwait; pa = iaddr;
      wc = iwait ? wc + 1 : 0;
      @(negedge CLK);
    end
    imemREN = 0; iwait = 0;
    @(negedge CLK);
  endtask

  task automatic expect_fetch(input string nm, input logic [31:0] a, input int w, input int ecyc);
    int cyc;
    logic [31:0] d;
    bit st;
    fetch(a, w, cyc, d, st);
    total += 3;
    if (cyc !== ecyc) begin bad++; $display("FAIL %s latency got=%0d want=%0d", nm, cyc, ecyc); end
    if (d !== memf(a)) begin bad++; $display("FAIL %s data got=%h want=%h", nm, d, memf(a)); end
    if (st !== 1'b1) begin bad++; $display("FAIL %s iaddr_stable got=%0d want=1", nm, st); end
  endtask

  task automatic test_reset;
    imemREN = 1; imemaddr = 0;
    repeat (2) @(negedge CLK);
    total += 4;
    if (ihit !== 0) begin bad++; $display("FAIL reset_ihit got=%b want=0", ihit); end
    if (imemload !== 0) begin bad++; $display("FAIL reset_load got=%h want=0", imemload); end
    if (iREN !== 0) begin bad++; $display("FAIL reset_iREN got=%b want=0", iREN); end
    if (iaddr !== 0) begin bad++; $display("FAIL reset_iaddr got=%h want=0", iaddr); end
    RST = 0; imemREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_first_fill;
    imemREN = 1; imemaddr = 0; iwait = 0;
    #1;
    total += 2;
    if (ihit !== 0) begin bad++; $display("FAIL fill_c0_ihit got=%b want=0", ihit); end
    if (iREN !== 0) begin bad++; $display("FAIL fill_c0_iREN got=%b want=0", iREN); end
    @(negedge CLK);
    total += 3;
    if (iREN !== 1) begin bad++; $display("FAIL fill_c1_iREN got=%b want=1", iREN); end
    if (iaddr !== 32'h0) begin bad++; $display("FAIL fill_c1_iaddr got=%h want=0", iaddr); end
    if (ihit !== 0) begin bad++; $display("FAIL fill_c1_ihit got=%b want=0", ihit); end
    @(negedge CLK);
    total += 3;
    if (iREN !== 1) begin bad++; $display("FAIL fill_c2_iREN got=%b want=1", iREN); end
    if (iaddr !== 32'h4) begin bad++; $display("FAIL fill_c2_iaddr got=%h want=4", iaddr); end
    if (ihit !== 0) begin bad++; $display("FAIL fill_c2_ihit got=%b want=0", ihit); end
    @(negedge CLK);
    total += 3;
    if (ihit !== 1) begin bad++; $display("FAIL fill_c3_ihit got=%b want=1", ihit); end
    if (imemload !== 32'h11) begin bad++; $display("FAIL fill_c3_load got=%h want=11", imemload); end
    if (iREN !== 0) begin bad++; $display("FAIL fill_c3_iREN got=%b want=0", iREN); end
    imemREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_hit;
    imemREN = 1; imemaddr = 32'h4;
    #1;
    total += 3;
    if (ihit !== 1) begin bad++; $display("FAIL hit_ihit got=%b want=1", ihit); end
    if (imemload !== 32'h22) begin bad++; $display("FAIL hit_load got=%h want=22", imemload); end
    if (iREN !== 0) begin bad++; $display("FAIL hit_iREN got=%b want=0", iREN); end
    imemREN = 0;
    #1;
    total++;
    if (imemload !== 0) begin bad++; $display("FAIL idle_load got=%h want=0", imemload); end
    @(negedge CLK);
  endtask

  task automatic test_flush_idle;
    imemREN = 1; imemaddr = 0; flush = 1;
    #1;
    total += 2;
    if (ihit !== 0) begin bad++; $display("FAIL flush_idle_ihit got=%b want=0", ihit); end
    if (imemload !== 0) begin bad++; $display("FAIL flush_idle_load got=%h want=0", imemload); end
    @(negedge CLK);
    flush = 0; imemREN = 0;
    #1;
    total++;
    if (iREN !== 0) begin bad++; $display("FAIL flush_idle_iREN got=%b want=0", iREN); end
    @(negedge CLK);
  endtask

  task automatic test_conflict;
    expect_fetch("conf_0", 32'h0, 0, 3);
    expect_fetch("conf_80", 32'h80, 0, 3);
    expect_fetch("conf_0_again", 32'h0, 0, 3);
    expect_fetch("conf_4_hit", 32'h4, 0, 0);
    expect_fetch("conf_84_miss", 32'h84, 0, 3);
  endtask

  task automatic test_wait;
    expect_fetch("wait_fill", 32'h100, 3, 9);
    expect_fetch("wait_hit", 32'h104, 0, 0);
  endtask

  task automatic test_addr_change;
    imemREN = 1; imemaddr = 32'h300;
    @(negedge CLK);
    imemREN = 0; imemaddr = 32'h10;
    @(negedge CLK);
    total++;
    if (iaddr !== 32'h304) begin bad++; $display("FAIL chg_iaddr got=%h want=304", iaddr); end
    @(negedge CLK);
    total++;
    if (iREN !== 0) begin bad++; $display("FAIL chg_done_iREN got=%b want=0", iREN); end
    expect_fetch("chg_hit", 32'h304, 0, 0);
  endtask

  task automatic test_flush_fill;
    imemREN = 1; imemaddr = 32'h200;
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (iaddr !== 32'h204) begin bad++; $display("FAIL fl_word2_iaddr got=%h want=204", iaddr); end
    flush = 1;
    @(negedge CLK);
    flush = 0; imemREN = 0;
    #1;
    total += 3;
    if (iREN !== 0) begin bad++; $display("FAIL fl_iREN got=%b want=0", iREN); end
    if (iaddr !== 0) begin bad++; $display("FAIL fl_iaddr got=%h want=0", iaddr); end
    if (ihit !== 0) begin bad++; $display("FAIL fl_ihit got=%b want=0", ihit); end
    @(negedge CLK);
    expect_fetch("fl_refill", 32'h200, 0, 3);
  endtask

  task automatic test_reset_mid_fill;
    imemREN = 1; imemaddr = 32'h400;
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    total += 3;
    if (iREN !== 0) begin bad++; $display("FAIL rst_iREN got=%b want=0", iREN); end
    if (iaddr !== 0) begin bad++; $display("FAIL rst_iaddr got=%h want=0", iaddr); end
    if (ihit !== 0) begin bad++; $display("FAIL rst_ihit got=%b want=0", ihit); end
    RST = 0; imemREN = 0;
    @(negedge CLK);
    expect_fetch("rst_miss_4", 32'h4, 0, 3);
    expect_fetch("rst_miss_104", 32'h104, 0, 3);
    expect_fetch("rst_miss_200", 32'h200, 0, 3);
  endtask

  initial begin
    test_reset;
    test_first_fill;
    test_hit;
    test_flush_idle;
    test_conflict;
    test_wait;
    test_addr_change;
    test_flush_fill;
    test_reset_mid_fill;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
